pipe_stall_ctrl: RTL and testbench

- Central sequencing controller for the 5-stage pipeline. Drives freeze/flush for the PC, the IF/ID register and the downstream stage registers.
- Merges three event sources:
  - a multi-cycle data-memory access, timed by an internal wait-state FSM;
  - the data-hazard request from the hazard detection unit;
  - taken-branch redirects from EXE.
- Keeps saturating performance counters for stall and flush cycles.

---
 rtl/pipe_stall_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl
//
// Sequencing controller for the 5-stage pipeline. It combines three event
// sources into freeze/flush controls:
//   - multi-cycle data-memory accesses, timed by an IDLE/WAIT/DONE FSM
//   - the data-hazard request from the hazard detection unit
//   - taken-branch redirects resolved in EXE
// Priority is memory stall > branch redirect > data hazard. It also keeps
// saturating performance counters of stall and flush cycles.
//
// Ports:
//   clk           clock
//   rst           asynchronous, active-low reset
//   mem_rd_en     MEM-stage instruction is a load
//   mem_wr_en     MEM-stage instruction is a store
//   hazard        data hazard detected in ID
//   branch_taken  EXE-stage branch resolved taken
//   pc_freeze     hold PC
//   if_freeze     hold IF/ID register
//   if_flush      clear IF/ID register
//   id_flush      clear ID/EXE register (bubble)
//   exe_freeze    hold ID/EXE and EXE/MEM registers
//   mem_freeze    hold MEM/WB register
//   mem_ready     one-cycle pulse, memory access completes this cycle
//   stall_count   number of cycles with pc_freeze=1 (saturating)
//   flush_count   number of cycles with if_flush=1 (saturating)
// ---------------------------------------------------------------------------
module pipe_stall_ctrl #(
    parameter int WAIT_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_rd_en,
    input  logic             mem_wr_en,
    input  logic             hazard,
    input  logic             branch_taken,
    output logic             pc_freeze,
    output logic             if_freeze,
    output logic             if_flush,
    output logic             id_flush,
    output logic             exe_freeze,
    output logic             mem_freeze,
    output logic             mem_ready,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // r_wcnt counts stall cycles already spent on the current access;
    // the access ends when it reaches WAIT_CYCLES-1 in WAIT.
    localparam logic [7:0]       LAST_CNT = 8'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t     r_state;
    logic [7:0] r_wcnt;

    logic       w_mem_req;
    logic       w_mem_stall;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic             en);
        if (en && (v != CNT_MAX)) begin
            return v + CNT_W'(1);
        end
        return v;
    endfunction

    assign w_mem_req = mem_rd_en | mem_wr_en;

    // The stall is Mealy: it is raised in the same cycle the request is seen
    // in IDLE, and drops in the very cycle the request is withdrawn in WAIT.
    assign w_mem_stall = rst && w_mem_req &&
                         ((r_state == IDLE) || (r_state == WAIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_wcnt  <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_mem_req) begin
                        r_wcnt <= 8'd1;
                        if (WAIT_CYCLES == 1) begin
                            r_state <= DONE;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!w_mem_req) begin
                        // Abort: no completion pulse for a withdrawn access.
                        r_state <= IDLE;
                        r_wcnt  <= 8'd0;
                    end else if (r_wcnt == LAST_CNT) begin
                        r_state <= DONE;
                        r_wcnt  <= 8'd0;
                    end else begin
                        r_wcnt <= r_wcnt + 8'd1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_wcnt  <= 8'd0;
                end
                default: begin
                    r_state <= IDLE;
                    r_wcnt  <= 8'd0;
                end
            endcase
        end
    end

    // While stalled, EXE/ID are held and re-present branch/hazard afterwards,
    // so they are ignored. A taken branch squashes the wrong-path hazard.
    always_comb begin
        pc_freeze  = 1'b0;
        if_freeze  = 1'b0;
        if_flush   = 1'b0;
        id_flush   = 1'b0;
        exe_freeze = 1'b0;
        mem_freeze = 1'b0;
        mem_ready  = 1'b0;
        if (rst) begin
            mem_ready = (r_state == DONE);
            if (w_mem_stall) begin
                pc_freeze  = 1'b1;
                if_freeze  = 1'b1;
                exe_freeze = 1'b1;
                mem_freeze = 1'b1;
            end else if (branch_taken) begin
                if_flush = 1'b1;
                id_flush = 1'b1;
            end else if (hazard) begin
                pc_freeze = 1'b1;
                if_freeze = 1'b1;
                id_flush  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            stall_count <= sat_inc(stall_count, pc_freeze);
            flush_count <= sat_inc(flush_count, if_flush);
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;

    logic        clk;
    logic        rst;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic        hazard;
    logic        branch_taken;

    logic        pc_freeze, if_freeze, if_flush, id_flush;
    logic        exe_freeze, mem_freeze, mem_ready;
    logic [15:0] stall_count, flush_count;

    logic        b_pc_freeze, b_if_freeze, b_if_flush, b_id_flush;
    logic        b_exe_freeze, b_mem_freeze, b_mem_ready;
    logic [3:0]  b_stall_count, b_flush_count;

    // ctl bit order: {pc_freeze, if_freeze, if_flush, id_flush,
    //                 exe_freeze, mem_freeze, mem_ready}
    localparam logic [6:0] C_NONE  = 7'b0000000;
    localparam logic [6:0] C_STALL = 7'b1100110;
    localparam logic [6:0] C_BR    = 7'b0011000;
    localparam logic [6:0] C_HZ    = 7'b1101000;
    localparam logic [6:0] C_DONE  = 7'b0000001;
    localparam logic [6:0] C_DNBR  = 7'b0011001;

    typedef struct {
        logic [6:0]  ctl;
        logic [15:0] sc;
        logic [15:0] fc;
        logic [3:0]  scb;
        logic [3:0]  fcb;
        string       name;
    } exp_t;

    exp_t sb[$];

    int tests = 0;
    int fails = 0;

    int m_sc  = 0;
    int m_fc  = 0;
    int m_scb = 0;
    int m_fcb = 0;

    pipe_stall_ctrl #(.WAIT_CYCLES(4), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_rd_en    (mem_rd_en),
        .mem_wr_en    (mem_wr_en),
        .hazard       (hazard),
        .branch_taken (branch_taken),
        .pc_freeze    (pc_freeze),
        .if_freeze    (if_freeze),
        .if_flush     (if_flush),
        .id_flush     (id_flush),
        .exe_freeze   (exe_freeze),
        .mem_freeze   (mem_freeze),
        .mem_ready    (mem_ready),
        .stall_count  (stall_count),
        .flush_count  (flush_count)
    );

    pipe_stall_ctrl #(.WAIT_CYCLES(4), .CNT_W(4)) dut_sat (
        .clk          (clk),
        .rst          (rst),
        .mem_rd_en    (mem_rd_en),
        .mem_wr_en    (mem_wr_en),
        .hazard       (hazard),
        .branch_taken (branch_taken),
        .pc_freeze    (b_pc_freeze),
        .if_freeze    (b_if_freeze),
        .if_flush     (b_if_flush),
        .id_flush     (b_id_flush),
        .exe_freeze   (b_exe_freeze),
        .mem_freeze   (b_mem_freeze),
        .mem_ready    (b_mem_ready),
        .stall_count  (b_stall_count),
        .flush_count  (b_flush_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input string what,
                       input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s %s: got %0h required %0h", nm, what, act, exp);
        end
    endtask

    // Monitor: one output sample per cycle, taken on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.name, "ctl",
                    32'({pc_freeze, if_freeze, if_flush, id_flush,
                         exe_freeze, mem_freeze, mem_ready}), 32'(e.ctl));
                chk(e.name, "stall_count", 32'(stall_count), 32'(e.sc));
                chk(e.name, "flush_count", 32'(flush_count), 32'(e.fc));
                chk(e.name, "sat_stall_count", 32'(b_stall_count), 32'(e.scb));
                chk(e.name, "sat_flush_count", 32'(b_flush_count), 32'(e.fcb));
                chk(e.name, "sat_ctl",
                    32'({b_pc_freeze, b_if_freeze, b_if_flush, b_id_flush,
                         b_exe_freeze, b_mem_freeze, b_mem_ready}), 32'(e.ctl));
            end
        end
    end

    // Drive one cycle of inputs and queue the hand-given control response.
    // Counter expectations follow from the expected controls of earlier cycles.
    task automatic step(input logic r, input logic rd, input logic wr,
                        input logic hz, input logic br,
                        input logic [6:0] ctl, input string nm);
        exp_t e;
        rst          = r;
        mem_rd_en    = rd;
        mem_wr_en    = wr;
        hazard       = hz;
        branch_taken = br;
        if (!r) begin
            m_sc = 0; m_fc = 0; m_scb = 0; m_fcb = 0;
        end
        e.ctl  = ctl;
        e.sc   = 16'(m_sc);
        e.fc   = 16'(m_fc);
        e.scb  = 4'(m_scb);
        e.fcb  = 4'(m_fcb);
        e.name = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (r) begin
            if (ctl[6]) begin
                m_sc++;
                if (m_scb < 15) m_scb++;
            end
            if (ctl[4]) begin
                m_fc++;
                if (m_fcb < 15) m_fcb++;
            end
        end
    endtask

    initial begin
        rst = 1'b0; mem_rd_en = 1'b0; mem_wr_en = 1'b0;
        hazard = 1'b0; branch_taken = 1'b0;
        @(posedge clk);
        #1;

        // Reset holds everything at zero regardless of inputs
        step(0, 1, 0, 1, 1, C_NONE, "reset0");
        step(0, 1, 0, 1, 1, C_NONE, "reset1");

        // Release with load pending: stall starts at once, branch/hazard ignored
        step(1, 1, 0, 1, 1, C_STALL, "load_s1");
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, C_STALL, "load_s");
        step(1, 1, 0, 0, 0, C_DONE, "load_done");
        step(1, 0, 0, 0, 0, C_NONE, "load_after");

        // Back-to-back store then load: one DONE cycle between stall windows
        for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0, C_STALL, "st_s");
        step(1, 0, 1, 0, 0, C_DONE, "st_done");
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, C_STALL, "ld_s");
        step(1, 1, 0, 0, 0, C_DONE, "ld_done");
        step(1, 0, 0, 0, 0, C_NONE, "b2b_after");

        // Branch beats hazard; then hazard alone
        step(1, 0, 0, 1, 1, C_BR, "br_hz");
        step(1, 0, 0, 1, 0, C_HZ, "hz_only");
        step(1, 0, 0, 0, 0, C_NONE, "idle");

        // Branch during stall: flush deferred to the DONE cycle
        step(1, 1, 0, 0, 0, C_STALL, "brst_s1");
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 1, C_STALL, "brst_s");
        step(1, 1, 0, 0, 1, C_DNBR, "brst_done");
        step(1, 0, 0, 0, 0, C_NONE, "brst_after");

        // Abort in WAIT, then a fresh full-length access
        step(1, 1, 0, 0, 0, C_STALL, "abort_s1");
        step(1, 0, 0, 0, 0, C_NONE, "abort_drop");
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, C_STALL, "fresh_s");
        step(1, 1, 0, 0, 0, C_DONE, "fresh_done");
        step(1, 0, 0, 0, 0, C_NONE, "fresh_after");

        // Reset in cycle 2 of an access, then a complete access from IDLE
        step(1, 1, 0, 0, 0, C_STALL, "rstmid_s1");
        step(0, 1, 0, 0, 0, C_NONE, "rstmid_rst");
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, C_STALL, "post_rst_s");
        step(1, 1, 0, 0, 0, C_DONE, "post_rst_done");
        step(1, 0, 0, 0, 0, C_NONE, "post_rst_idle");

        // Long hazard: narrow counters saturate at 15
        for (int i = 0; i < 20; i++) step(1, 0, 0, 1, 0, C_HZ, "sat_hz");
        step(1, 0, 0, 0, 0, C_NONE, "sat_end");
        step(1, 0, 0, 0, 0, C_NONE, "sat_hold");

        for (int i = 0; i < 4 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
